// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer with edge pulses, long-press detection and
// auto-repeat. Every channel runs its own synchroniser, debounce counter and
// hold FSM; channels share nothing but the clock and reset.
module key_debounce_array #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_pulse
);

  // Debounce counter spans 0..DEBOUNCE_CYCLES-1; it saturates instead of wrapping.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The hold counter is shared by the long-press and repeat phases, so it is
  // sized for whichever period is longer.
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_MAX  = HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan

    logic              sync_a;
    logic              sync_b;
    logic              candidate;
    logic [CNT_W-1:0]  cnt;
    logic              clean;
    logic              rise_q;
    logic              fall_q;
    logic              settle;
    logic              rise_next;
    logic              fall_next;

    hold_state_t       state;
    hold_state_t       state_next;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_next;
    logic              long_q;
    logic              long_next;
    logic              repeat_q;
    logic              repeat_next;

    // The clean level flips once the candidate has been stable for the full window.
    always_comb begin
      settle    = (sync_b == candidate) && !(cnt < CNT_MAX) && (clean != candidate);
      rise_next = settle && candidate;
      fall_next = settle && !candidate;
    end

    // Synchroniser, candidate tracking and debounce counter with registered edge pulses.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_a    <= INIT_LEVEL;
        sync_b    <= INIT_LEVEL;
        candidate <= INIT_LEVEL;
        cnt       <= '0;
        clean     <= INIT_LEVEL;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
      end else begin
        sync_a <= noisy_in[ch];
        sync_b <= sync_a;
        if (sync_b != candidate) begin
          candidate <= sync_b;
          cnt       <= '0;
        end else if (cnt < CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else if (clean != candidate) begin
          clean <= candidate;
        end
        rise_q <= rise_next;
        fall_q <= fall_next;
      end
    end

    // Hold FSM next state: a release overrides everything, including a pulse due this edge.
    always_comb begin
      state_next  = state;
      hcnt_next   = hcnt;
      long_next   = 1'b0;
      repeat_next = 1'b0;
      if (fall_next) begin
        state_next = IDLE;
        hcnt_next  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_next) begin
              state_next = PRESSED;
              hcnt_next  = '0;
            end
          end
          PRESSED: begin
            if (hcnt == LONG_MAX) begin
              long_next  = 1'b1;
              hcnt_next  = '0;
              state_next = HELD;
            end else begin
              hcnt_next = hcnt + 1'b1;
            end
          end
          HELD: begin
            if (REPEAT_CYCLES != 0) begin
              if (hcnt == REP_MAX) begin
                repeat_next = 1'b1;
                hcnt_next   = '0;
              end else begin
                hcnt_next = hcnt + 1'b1;
              end
            end
          end
          default: begin
            state_next = IDLE;
            hcnt_next  = '0;
          end
        endcase
      end
    end

    // Hold FSM state, counter and registered long/repeat pulses.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state    <= INIT_LEVEL ? PRESSED : IDLE;
        hcnt     <= '0;
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        state    <= state_next;
        hcnt     <= hcnt_next;
        long_q   <= long_next;
        repeat_q <= repeat_next;
      end
    end

    assign clean_out[ch]    = clean;
    assign rise_pulse[ch]   = rise_q;
    assign fall_pulse[ch]   = fall_q;
    assign long_press[ch]   = long_q;
    assign repeat_pulse[ch] = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array: directed scenarios plus random
// key activity, all compared cycle by cycle against a sliding-window model.
module tb_key_debounce_array;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int LNG = 10;
  localparam int REP = 5;
  localparam int HL  = DEB + 3;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] noisy_in;
  logic [NCH-1:0] clean_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
  logic [NCH-1:0] long_press;
  logic [NCH-1:0] repeat_pulse;

  key_debounce_array #(
    .CHANNELS        (NCH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP),
    .INIT_LEVEL      (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .noisy_in     (noisy_in),
    .clean_out    (clean_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  typedef struct packed {
    int             edge_no;
    logic [NCH-1:0] c;
    logic [NCH-1:0] r;
    logic [NCH-1:0] f;
    logic [NCH-1:0] l;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;

  int n_rise[NCH];
  int n_fall[NCH];
  int n_long[NCH];
  int n_rep[NCH];
  int last_rise[NCH];
  int last_fall[NCH];
  int last_long[NCH];
  int last_rep[NCH];

  int base_rise[NCH];
  int base_fall[NCH];
  int base_long[NCH];
  int base_rep[NCH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a channel's clean level becomes v once the last DEB+1
  // synchronised samples (two cycles old) all equal v. Long and repeat pulses
  // follow from the distance in edges to the press.
  initial begin
    logic [NCH-1:0] hist [HL];
    logic [NCH-1:0] clean_m;
    logic [NCH-1:0] held_m;
    int             press_edge [NCH];
    exp_t           e;
    for (int i = 0; i < HL; i++) hist[i] = '0;
    clean_m = '0;
    held_m  = '0;
    for (int ch = 0; ch < NCH; ch++) press_edge[ch] = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      e         = '0;
      e.edge_no = edge_cnt;
      if (!reset) begin
        for (int i = 0; i < HL; i++) hist[i] = '0;
        clean_m = '0;
        held_m  = '0;
      end else begin
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = noisy_in;
        for (int ch = 0; ch < NCH; ch++) begin
          logic v;
          bit   stable;
          int   d;
          v      = hist[2][ch];
          stable = 1'b1;
          for (int j = 2; j < HL; j++) if (hist[j][ch] != v) stable = 1'b0;
          if (stable && (v != clean_m[ch])) begin
            clean_m[ch] = v;
            if (v) begin
              e.r[ch]        = 1'b1;
              held_m[ch]     = 1'b1;
              press_edge[ch] = edge_cnt;
            end else begin
              e.f[ch]    = 1'b1;
              held_m[ch] = 1'b0;
            end
          end else if (held_m[ch]) begin
            d = edge_cnt - press_edge[ch];
            if (d == LNG) e.l[ch] = 1'b1;
            else if ((REP != 0) && (d > LNG) && (((d - LNG) % REP) == 0)) e.p[ch] = 1'b1;
          end
        end
      end
      e.c = clean_m;
      exp_q.push_back(e);
    end
  end

  // Monitor: on every falling edge compare what the DUT presents against the
  // oldest expectation, and log pulse times for the directed checks.
  initial begin
    exp_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      n_rise[ch] = 0; n_fall[ch] = 0; n_long[ch] = 0; n_rep[ch] = 0;
      last_rise[ch] = -1; last_fall[ch] = -1; last_long[ch] = -1; last_rep[ch] = -1;
    end
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("cycle_outputs@%0d", e.edge_no),
                    32'({clean_out, rise_pulse, fall_pulse, long_press, repeat_pulse}),
                    32'({e.c, e.r, e.f, e.l, e.p}));
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (rise_pulse[ch])   begin n_rise[ch]++; last_rise[ch] = edge_cnt; end
        if (fall_pulse[ch])   begin n_fall[ch]++; last_fall[ch] = edge_cnt; end
        if (long_press[ch])   begin n_long[ch]++; last_long[ch] = edge_cnt; end
        if (repeat_pulse[ch]) begin n_rep[ch]++;  last_rep[ch]  = edge_cnt; end
      end
    end
  end

  task automatic snapshot();
    for (int ch = 0; ch < NCH; ch++) begin
      base_rise[ch] = n_rise[ch];
      base_fall[ch] = n_fall[ch];
      base_long[ch] = n_long[ch];
      base_rep[ch]  = n_rep[ch];
    end
  endtask

  task automatic applyStimulus(input int ch, input logic v, input int cycles);
    noisy_in[ch] = v;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int t;
    noisy_in = '0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #1 checkOutput("reset_state",
                   32'({clean_out, rise_pulse, fall_pulse, long_press, repeat_pulse}), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // ch0 pressed and held: rise, long press, two repeats
    snapshot();
    t = edge_cnt;
    applyStimulus(0, 1'b1, 30);
    checkOutput("ch0_rise_edge",  32'(last_rise[0]), 32'(t + 7));
    checkOutput("ch0_long_edge",  32'(last_long[0]), 32'(t + 17));
    checkOutput("ch0_last_rep",   32'(last_rep[0]),  32'(t + 27));
    checkOutput("ch0_rep_count",  32'(n_rep[0] - base_rep[0]), 32'd2);
    checkOutput("ch0_rise_count", 32'(n_rise[0] - base_rise[0]), 32'd1);

    // reset while ch0 is held, then release with the key still down
    #2 reset = 1'b0;
    #1 checkOutput("reset_in_held",
                   32'({clean_out, rise_pulse, fall_pulse, long_press, repeat_pulse}), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    t = edge_cnt;
    snapshot();
    repeat (10) @(negedge clk);
    checkOutput("ch0_rise_after_reset", 32'(last_rise[0]), 32'(t + 7));
    checkOutput("ch0_rise_count_after_reset", 32'(n_rise[0] - base_rise[0]), 32'd1);
    applyStimulus(0, 1'b0, 15);

    // ch1 bounces then settles high
    snapshot();
    applyStimulus(1, 1'b1, 3);
    applyStimulus(1, 1'b0, 3);
    t = edge_cnt;
    applyStimulus(1, 1'b1, 15);
    checkOutput("ch1_rise_count", 32'(n_rise[1] - base_rise[1]), 32'd1);
    checkOutput("ch1_rise_edge",  32'(last_rise[1]), 32'(t + 7));
    checkOutput("ch1_fall_count", 32'(n_fall[1] - base_fall[1]), 32'd0);
    applyStimulus(1, 1'b0, 12);

    // ch2 short glitch is filtered out
    snapshot();
    applyStimulus(2, 1'b1, 3);
    applyStimulus(2, 1'b0, 15);
    checkOutput("ch2_rise_count", 32'(n_rise[2] - base_rise[2]), 32'd0);
    checkOutput("ch2_fall_count", 32'(n_fall[2] - base_fall[2]), 32'd0);

    // ch3 released while PRESSED with hcnt at 8
    snapshot();
    t = edge_cnt;
    applyStimulus(3, 1'b1, 9);
    applyStimulus(3, 1'b0, 20);
    checkOutput("ch3_fall_edge",  32'(last_fall[3]), 32'(t + 16));
    checkOutput("ch3_long_count", 32'(n_long[3] - base_long[3]), 32'd0);
    checkOutput("ch3_rep_count",  32'(n_rep[3] - base_rep[3]), 32'd0);

    // ch3 released on the very edge the long press would fire
    snapshot();
    t = edge_cnt;
    applyStimulus(3, 1'b1, 10);
    applyStimulus(3, 1'b0, 20);
    checkOutput("ch3_fall_on_long_edge", 32'(last_fall[3]), 32'(t + 17));
    checkOutput("ch3_long_suppressed",   32'(n_long[3] - base_long[3]), 32'd0);

    // ch0 and ch1 pressed together
    snapshot();
    t = edge_cnt;
    noisy_in[0] = 1'b1;
    noisy_in[1] = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("pair_ch0_rise", 32'(last_rise[0]), 32'(t + 7));
    checkOutput("pair_ch1_rise", 32'(last_rise[1]), 32'(t + 7));
    checkOutput("pair_ch0_long", 32'(last_long[0]), 32'(t + 17));
    checkOutput("pair_ch1_long", 32'(last_long[1]), 32'(t + 17));
    noisy_in[0] = 1'b0;
    noisy_in[1] = 1'b0;
    repeat (15) @(negedge clk);

    // random key activity with occasional resets
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
      end
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 15) == 0) noisy_in[ch] = ~noisy_in[ch];
      @(negedge clk);
    end
    noisy_in = '0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
